pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
Controller for the 1024-entry timestamped LED pattern memory. It generates the 10-bit playback timestamp `counter10h` from CLOCK50M through a prescaler. It arbitrates two write requesters (host bus, serial loader) onto the memory's single write port, and runs a full-memory clear sweep. It also latches the pattern read back at each timestamp step for the LED driver.

Parameters:
- TICK_DIV, 5000000, CLOCK50M cycles per timestamp step (100 ms at 50 MHz); legal range >= 2.
- LOOP_LEN, 1024, number of timestamp steps per loop; `counter10h` wraps from LOOP_LEN-1 to 0; legal range 2..1024.

Ports:
- CLOCK50M  in  1  system clock, 50 MHz
- RESET  in  1  asynchronous, active-high reset
- start  in  1  begin or resume playback (1-cycle pulse)
- stop  in  1  pause playback; timestamp holds
- clear  in  1  zero the memory and rewind the timestamp
- req0_valid  in  1  host write request
- req0_data  in  18  host entry {timestamp[9:0], pattern[7:0]}
- req0_ready  out  1  host request accepted this cycle
- req1_valid  in  1  loader write request
- req1_data  in  18  loader entry, same format
- req1_ready  out  1  loader request accepted this cycle
- mem_write  out  1  pattern memory write strobe
- mem_address  out  2  pattern memory register select; constant 2'b00
- mem_data  out  18  pattern memory write data
- counter10h  out  10  playback timestamp / memory read index
- pattern_in  in  8  pattern memory combinational read data
- pattern_latched  out  8  pattern for the current step
- tick  out  1  1-cycle pulse on each timestamp step
- running  out  1  high in RUN state
- busy  out  1  high in CLEAR state

Behaviour:
- Reset (async): state=IDLE; prescaler=0; counter10h=0; pattern_latched=0; tick=0; mem_write=0; mem_data=0; arbiter priority=req0; both readies=0.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE.
  - IDLE/RUN: clear -> CLEAR.
  - CLEAR: sweep done -> IDLE.
- Precedence when pulses coincide: clear > stop > start. start and stop are ignored during CLEAR; clear during CLEAR is ignored.
- Prescaler advances only in RUN. It counts 0..TICK_DIV-1; at TICK_DIV-1 it returns to 0 and asserts tick for one cycle (registered). In the same edge, counter10h increments, and wraps LOOP_LEN-1 -> 0.
- IDLE holds both prescaler and counter10h, so start resumes mid-interval.
- Entry into CLEAR zeroes the prescaler and counter10h.
- pattern_latched samples pattern_in on the cycle after tick is high, i.e. 2 cycles after the counter update edge, so memory read data has settled. It holds otherwise; not updated in IDLE/CLEAR.
- Arbitration, IDLE/RUN only:
  - reqN_ready is combinational from valid, priority and state. At most one ready per cycle; a transfer is valid&&ready.
  - If both request, the priority holder wins. After any grant, priority passes to the other requester.
  - A lone request is granted immediately.
  - Both readies are 0 in CLEAR; requesters stall and must hold data.
- Write latency: a transfer at edge n drives mem_write=1 and mem_data=granted data in cycle n+1. mem_write=0 otherwise. Requester data is passed unchanged; no range check on the timestamp field.
- Clear sweep: CLEAR writes one entry per cycle, mem_data={k[9:0],8'h00} for k=0..1023, with mem_write=1 each cycle. The sweep covers all 1024 entries regardless of LOOP_LEN. After k=1023 is issued, the state returns to IDLE and busy falls the same edge.
- A write already in flight when clear arrives completes in the next cycle, before the sweep's first write.
- Reset during a sweep aborts it; memory contents are left undefined for the partially cleared region.
- mem_address is tied to 2'b00.

Decomposition:
- Shared package pattern_pkg:
  - state enum {IDLE, RUN, CLEAR}
  - TS_W=10, PAT_W=8, ENTRY_W=18
  - MEM_DEPTH=1024
  - MEM_SEL_PATTERN=2'b00
- Sub-module rr_arbiter2: 2-way round-robin arbiter with enable input, grant outputs and registered priority bit.
- Prescaler, counter, FSM and sweep stay in the top module.

Test Plan:
- TICK_DIV=4, LOOP_LEN=8; reset, then start -> tick every 4 cycles; counter10h 0,1,..,7,0; pattern_latched equals pattern_in 2 cycles after each counter change.
- Stop after counter10h=3 plus 2 prescaler cycles, hold 10 cycles, then start -> counter stays 3; next tick arrives 2 cycles after resume.
- req0 and req1 both valid for 4 cycles with 18'h0_0A5 and 18'h3_FF0 -> grants alternate req0, req1, req0, req1; mem_data follows the same order, 1 cycle behind.
- clear in RUN at counter10h=5 -> busy for 1024 cycles; mem_data 18'h00000, 18'h00100, ..., 18'h3FF00; then IDLE with counter10h=0; req1 held valid is not granted until busy falls.
- clear, stop and start asserted in the same cycle -> CLEAR entered; start is ignored (running stays 0 after the sweep).
- RESET asserted mid-sweep at k=100 -> immediately mem_write=0, busy=0, counter10h=0, IDLE.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Entry layout is {timestamp, pattern}.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int TS_W      = 10;
  localparam int PAT_W     = 8;
  localparam int ENTRY_W   = 18;
  localparam int MEM_DEPTH = 1024;

  localparam logic [1:0] MEM_SEL_PATTERN = 2'b00;

  // Blank entry written by the clear sweep for timestamp k.
  function automatic logic [ENTRY_W-1:0] clear_entry(
    input logic [TS_W-1:0] k
  );
    return {k, {PAT_W{1'b0}}};
  endfunction

endpackage

// File: rtl/pattern_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter with enable.
// Priority flips to the other side after every grant.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // 0: req0 holds priority, 1: req1 holds priority
  logic prio;

  // Grant the lone requester, or the priority holder on contention
  always_comb begin
    gnt0 = en & req0 & (~req1 | ~prio);
    gnt1 = en & req1 & (~req0 | prio);
  end

  // Hand priority to the loser of each grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (gnt0) begin
      prio <= 1'b1;
    end else if (gnt1) begin
      prio <= 1'b0;
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Playback controller for the timestamped LED pattern memory:
// timebase, write-port arbitration, clear sweep and pattern latch.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int TICK_DIV = 5000000,
  parameter int LOOP_LEN = 1024
) (
  input  logic               CLOCK50M,
  input  logic               RESET,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               req0_valid,
  input  logic [ENTRY_W-1:0] req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [ENTRY_W-1:0] req1_data,
  output logic               req1_ready,
  output logic               mem_write,
  output logic [1:0]         mem_address,
  output logic [ENTRY_W-1:0] mem_data,
  output logic [TS_W-1:0]    counter10h,
  input  logic [PAT_W-1:0]   pattern_in,
  output logic [PAT_W-1:0]   pattern_latched,
  output logic               tick,
  output logic               running,
  output logic               busy
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [TS_W-1:0]  TS_LAST  = TS_W'(LOOP_LEN - 1);
  localparam logic [TS_W-1:0]  K_LAST   = TS_W'(MEM_DEPTH - 1);

  state_t             state;
  state_t             state_next;
  logic [PRE_W-1:0]   prescaler;
  logic [TS_W-1:0]    sweep;
  logic               tick_d;
  logic               enter_clear;
  logic               advance;
  logic               gnt0;
  logic               gnt1;

  assign mem_address = MEM_SEL_PATTERN;
  assign running     = (state == RUN);
  assign busy        = (state == CLEAR);
  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;

  rr_arbiter2 u_arb (
    .clk  (CLOCK50M),
    .rst  (RESET),
    .en   (state != CLEAR),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Next state: clear beats stop beats start; sweep end returns to IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (clear)      state_next = CLEAR;
        else if (start) state_next = RUN;
      end
      RUN: begin
        if (clear)      state_next = CLEAR;
        else if (stop)  state_next = IDLE;
      end
      CLEAR: begin
        if (sweep == K_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign enter_clear = (state != CLEAR) && (state_next == CLEAR);
  assign advance     = (state == RUN) && (state_next == RUN);

  // State register
  always_ff @(posedge CLOCK50M or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Prescaler and timestamp; a pause freezes both mid-interval
  always_ff @(posedge CLOCK50M or posedge RESET) begin
    if (RESET) begin
      prescaler  <= '0;
      counter10h <= '0;
      tick       <= 1'b0;
    end else if (enter_clear) begin
      prescaler  <= '0;
      counter10h <= '0;
      tick       <= 1'b0;
    end else if (advance && prescaler == PRE_LAST) begin
      prescaler  <= '0;
      tick       <= 1'b1;
      counter10h <= (counter10h == TS_LAST) ? '0
                                            : counter10h + TS_W'(1);
    end else if (advance) begin
      prescaler  <= prescaler + PRE_W'(1);
      tick       <= 1'b0;
    end else begin
      tick       <= 1'b0;
    end
  end

  // Sweep index: restarts on clear entry, steps once per CLEAR cycle
  always_ff @(posedge CLOCK50M or posedge RESET) begin
    if (RESET)            sweep <= '0;
    else if (enter_clear) sweep <= '0;
    else if (busy)        sweep <= sweep + TS_W'(1);
  end

  // Registered write port: sweep entries, else the granted request
  always_ff @(posedge CLOCK50M or posedge RESET) begin
    if (RESET) begin
      mem_write <= 1'b0;
      mem_data  <= '0;
    end else begin
      mem_write <= 1'b0;
      if (busy) begin
        mem_write <= 1'b1;
        mem_data  <= clear_entry(sweep);
      end else if (gnt0) begin
        mem_write <= 1'b1;
        mem_data  <= req0_data;
      end else if (gnt1) begin
        mem_write <= 1'b1;
        mem_data  <= req1_data;
      end
    end
  end

  // Latch read data one cycle after tick so the memory has settled
  always_ff @(posedge CLOCK50M or posedge RESET) begin
    if (RESET) begin
      tick_d          <= 1'b0;
      pattern_latched <= '0;
    end else begin
      tick_d <= tick;
      if (running && tick_d) pattern_latched <= pattern_in;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer.
// Directed scenarios plus random traffic against a behavioural model.
module tb_pattern_sequencer;

  localparam int TICK_DIV = 4;
  localparam int LOOP_LEN = 8;

  logic        CLOCK50M;
  logic        RESET;
  logic        start;
  logic        stop;
  logic        clear;
  logic        req0_valid;
  logic [17:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [17:0] req1_data;
  logic        req1_ready;
  logic        mem_write;
  logic [1:0]  mem_address;
  logic [17:0] mem_data;
  logic [9:0]  counter10h;
  logic [7:0]  pattern_in;
  logic [7:0]  pattern_latched;
  logic        tick;
  logic        running;
  logic        busy;

  logic [7:0] lut [1024];

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode 0 idle, 1 run, 2 clear
  int          m_mode;
  int          m_pre;
  int          m_cnt;
  int          m_k;
  bit          m_tick;
  bit          m_tickd;
  bit          m_prio;
  bit          m_wr;
  logic [17:0] m_data;
  logic [7:0]  m_lat;

  pattern_sequencer #(
    .TICK_DIV (TICK_DIV),
    .LOOP_LEN (LOOP_LEN)
  ) dut (
    .CLOCK50M        (CLOCK50M),
    .RESET           (RESET),
    .start           (start),
    .stop            (stop),
    .clear           (clear),
    .req0_valid      (req0_valid),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_data        (mem_data),
    .counter10h      (counter10h),
    .pattern_in      (pattern_in),
    .pattern_latched (pattern_latched),
    .tick            (tick),
    .running         (running),
    .busy            (busy)
  );

  initial CLOCK50M = 1'b0;
  always #5 CLOCK50M = ~CLOCK50M;

  always_comb pattern_in = lut[counter10h];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pre = 0; m_cnt = 0; m_k = 0;
    m_tick = 0; m_tickd = 0; m_prio = 0; m_wr = 0;
    m_data = '0; m_lat = '0;
  endtask

  task automatic check_outputs();
    chk("running", running, (m_mode == 1));
    chk("busy", busy, (m_mode == 2));
    chk("counter10h", counter10h, m_cnt);
    chk("tick", tick, m_tick);
    chk("mem_write", mem_write, m_wr);
    chk("mem_data", mem_data, m_data);
    chk("pattern_latched", pattern_latched, m_lat);
    chk("mem_address", mem_address, 0);
  endtask

  // One clock: check readies, predict next cycle, clock, compare.
  task automatic step();
    bit r0, r1, nwr, nprio, ntick;
    int nmode, npre, ncnt, nk;
    logic [17:0] ndata;
    logic [7:0]  nlat;
    #1;
    r0 = 0; r1 = 0;
    if (m_mode != 2) begin
      if (req0_valid && req1_valid) begin
        r0 = !m_prio; r1 = m_prio;
      end else begin
        r0 = req0_valid; r1 = req1_valid;
      end
    end
    chk("req0_ready", req0_ready, r0);
    chk("req1_ready", req1_ready, r1);
    nmode = m_mode;
    if (m_mode == 2) begin
      if (m_k == 1023) nmode = 0;
    end else if (clear) nmode = 2;
    else if (m_mode == 1 && stop) nmode = 0;
    else if (m_mode == 0 && start) nmode = 1;
    nwr = 0; ndata = m_data; nk = m_k; nprio = m_prio;
    if (m_mode == 2) begin
      nwr = 1; ndata = 18'(m_k) << 8; nk = m_k + 1;
    end else if (r0) begin
      nwr = 1; ndata = req0_data; nprio = 1;
    end else if (r1) begin
      nwr = 1; ndata = req1_data; nprio = 0;
    end
    npre = m_pre; ncnt = m_cnt; ntick = 0;
    if (m_mode != 2 && nmode == 2) begin
      npre = 0; ncnt = 0; nk = 0;
    end else if (m_mode == 1 && nmode == 1) begin
      npre = m_pre + 1;
      if (npre == TICK_DIV) begin
        npre = 0; ntick = 1; ncnt = (m_cnt + 1) % LOOP_LEN;
      end
    end
    nlat = m_lat;
    if (m_mode == 1 && m_tickd) nlat = lut[m_cnt];
    @(posedge CLOCK50M);
    #1;
    m_mode = nmode; m_pre = npre; m_cnt = ncnt; m_k = nk;
    m_tickd = m_tick; m_tick = ntick; m_prio = nprio;
    m_wr = nwr; m_data = ndata; m_lat = nlat;
    check_outputs();
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; clear = 0;
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    int busy_cnt;
    logic [17:0] seq [4];
    for (int i = 0; i < 1024; i++) lut[i] = 8'($urandom);
    idle_inputs();
    req0_data = '0; req1_data = '0;
    RESET = 1;
    model_reset();
    repeat (3) @(posedge CLOCK50M);
    #1;
    check_outputs();
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_req1_ready", req1_ready, 0);
    RESET = 0;

    // playback with wrap
    start = 1; step(); start = 0;
    repeat (40) step();

    // pause mid-interval and resume
    for (int i = 0; i < 100; i++) begin
      if (m_cnt == 3 && m_pre == 2) break;
      step();
    end
    chk("reach_cnt3_pre2", (m_cnt == 3 && m_pre == 2), 1);
    stop = 1; step(); stop = 0;
    repeat (10) step();
    chk("held_counter", counter10h, 3);
    start = 1; step(); start = 0;
    chk("resume_tick_0", tick, 0);
    step();
    chk("resume_tick_1", tick, 0);
    step();
    chk("resume_tick_2", tick, 1);
    chk("resume_counter", counter10h, 4);
    repeat (6) step();

    // contention: grants alternate starting with req0
    seq[0] = 18'h000A5; seq[1] = 18'h03FF0;
    seq[2] = 18'h000A5; seq[3] = 18'h03FF0;
    req0_valid = 1; req0_data = 18'h000A5;
    req1_valid = 1; req1_data = 18'h03FF0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_order", mem_data, seq[i]);
    end
    idle_inputs();
    step();

    // random traffic, no clear
    for (int i = 0; i < 300; i++) begin
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      req0_data  = 18'($urandom);
      req1_data  = 18'($urandom);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      step();
    end
    idle_inputs();

    // clear in RUN at counter 5 with req1 waiting
    start = 1; step(); start = 0;
    req1_valid = 1; req1_data = 18'h2ABCD;
    for (int i = 0; i < 200; i++) begin
      if (m_cnt == 5 && m_mode == 1) break;
      step();
    end
    chk("reach_cnt5", (m_cnt == 5 && m_mode == 1), 1);
    busy_cnt = 0;
    clear = 1; step(); clear = 0;
    if (busy === 1'b1) busy_cnt++;
    for (int i = 0; i < 1100; i++) begin
      if (m_mode != 2) break;
      step();
      if (busy === 1'b1) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, 1024);
    chk("after_clear_counter", counter10h, 0);
    repeat (3) step();
    idle_inputs();
    step();

    // clear, stop and start together from IDLE
    clear = 1; stop = 1; start = 1; step();
    idle_inputs();
    chk("combo_busy", busy, 1);
    for (int i = 0; i < 1100; i++) begin
      if (m_mode != 2) break;
      step();
    end
    repeat (3) step();
    chk("combo_running", running, 0);

    // reset in the middle of a sweep
    start = 1; step(); start = 0;
    repeat (5) step();
    clear = 1; step(); clear = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_k == 100) break;
      step();
    end
    chk("reach_k100", m_k, 100);
    RESET = 1;
    #1;
    model_reset();
    chk("rst_mem_write", mem_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_counter", counter10h, 0);
    chk("rst_running", running, 0);
    step();
    RESET = 0;
    start = 1; step(); start = 0;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
